// File: rtl/dsp_regs_pkg.sv
// Shared definitions for the DSP convolution engine AXI4-Lite register file:
// register map, control/status bit positions, response codes and FSM states.
package dsp_regs_pkg;

   localparam logic [2:0] REG_CTRL       = 3'd0;
   localparam logic [2:0] REG_STATUS     = 3'd1;
   localparam logic [2:0] REG_SRC_ADDR   = 3'd2;
   localparam logic [2:0] REG_DST_ADDR   = 3'd3;
   localparam logic [2:0] REG_COEFF_ADDR = 3'd4;
   localparam logic [2:0] REG_LENGTH     = 3'd5;
   localparam logic [2:0] REG_ID         = 3'd6;

   localparam int unsigned CTRL_START_BIT  = 0;
   localparam int unsigned CTRL_IRQ_EN_BIT = 1;
   localparam int unsigned STAT_BUSY_BIT   = 0;
   localparam int unsigned STAT_DONE_BIT   = 1;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic {W_IDLE, W_RESP} w_state_e;
   typedef enum logic {R_IDLE, R_DATA} r_state_e;

   function automatic logic is_aligned(input logic [1:0] addr_lsb);
      return addr_lsb == 2'b00;
   endfunction

endpackage

// File: rtl/axil_wstrb_merge.sv
// Byte-lane merge of a write into an existing register value: lanes with
// their strobe set take the new data, the rest keep the old value.
module axil_wstrb_merge #(
   parameter int unsigned W = 32
) (
   input  logic [W-1:0]   i_old,
   input  logic [W-1:0]   i_wdata,
   input  logic [W/8-1:0] i_wstrb,
   output logic [W-1:0]   o_merged
);

   always_comb begin
      o_merged = i_old;
      for (int b = 0; b < W / 8; b++) begin
         if (i_wstrb[b]) begin
            o_merged[8*b +: 8] = i_wdata[8*b +: 8];
         end
      end
   end

endmodule

// File: rtl/dsp_axil_regs.sv
// AXI4-Lite responder exposing control, status and buffer configuration
// registers of the DSP 1-D convolution engine, with a done interrupt.
module dsp_axil_regs
   import dsp_regs_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned DATA_WIDTH = 32,
   parameter logic [31:0] ID_VALUE   = 32'hD5C0_0001
) (
   input  logic                    clk_i,
   input  logic                    reset_ni,
   input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr_i,
   input  logic                    s_axi_awvalid_i,
   output logic                    s_axi_awready_o,
   input  logic [DATA_WIDTH-1:0]   s_axi_wdata_i,
   input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb_i,
   input  logic                    s_axi_wvalid_i,
   output logic                    s_axi_wready_o,
   output logic [1:0]              s_axi_bresp_o,
   output logic                    s_axi_bvalid_o,
   input  logic                    s_axi_bready_i,
   input  logic [ADDR_WIDTH-1:0]   s_axi_araddr_i,
   input  logic                    s_axi_arvalid_i,
   output logic                    s_axi_arready_o,
   output logic [DATA_WIDTH-1:0]   s_axi_rdata_o,
   output logic [1:0]              s_axi_rresp_o,
   output logic                    s_axi_rvalid_o,
   input  logic                    s_axi_rready_i,
   input  logic                    core_busy_i,
   input  logic                    core_done_i,
   output logic                    start_o,
   output logic [31:0]             src_addr_o,
   output logic [31:0]             dst_addr_o,
   output logic [31:0]             coeff_addr_o,
   output logic [15:0]             length_o,
   output logic                    irq_o
);

   w_state_e r_wstate, w_wstate_next;
   r_state_e r_rstate, w_rstate_next;

   logic                    r_aw_held, r_w_held;
   logic [ADDR_WIDTH-1:0]   r_awaddr;
   logic [DATA_WIDTH-1:0]   r_wdata;
   logic [DATA_WIDTH/8-1:0] r_wstrb;
   logic [1:0]              r_bresp, r_rresp;
   logic [DATA_WIDTH-1:0]   r_rdata;

   logic [DATA_WIDTH-1:0]   r_src, r_dst, r_coeff;
   logic [15:0]             r_length;
   logic                    r_irq_en, r_done, r_start, r_irq;

   logic                    w_aw_hs, w_w_hs, w_ar_hs, w_commit, w_aligned, w_wr_en;
   logic [ADDR_WIDTH-1:0]   w_addr;
   logic [DATA_WIDTH-1:0]   w_data, w_old, w_merged, w_rd_word;
   logic [DATA_WIDTH/8-1:0] w_strb;
   logic [2:0]              w_idx;
   logic                    w_start_req, w_done_clr, w_done_next;

   // ---------------- write channel ----------------
   assign s_axi_awready_o = (r_wstate == W_IDLE) && !r_aw_held;
   assign s_axi_wready_o  = (r_wstate == W_IDLE) && !r_w_held;
   assign s_axi_bvalid_o  = (r_wstate == W_RESP);
   assign s_axi_bresp_o   = r_bresp;

   assign w_aw_hs = s_axi_awvalid_i && s_axi_awready_o;
   assign w_w_hs  = s_axi_wvalid_i && s_axi_wready_o;
   // Commit as soon as both halves are present, either held or arriving now.
   assign w_commit = (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);

   assign w_addr    = r_aw_held ? r_awaddr : s_axi_awaddr_i;
   assign w_data    = r_w_held ? r_wdata : s_axi_wdata_i;
   assign w_strb    = r_w_held ? r_wstrb : s_axi_wstrb_i;
   assign w_idx     = w_addr[4:2];
   assign w_aligned = is_aligned(w_addr[1:0]);
   assign w_wr_en   = w_commit && w_aligned;

   always_comb begin
      w_wstate_next = r_wstate;
      unique case (r_wstate)
         W_IDLE: if (w_commit) w_wstate_next = W_RESP;
         W_RESP: if (s_axi_bready_i) w_wstate_next = W_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         r_wstate  <= W_IDLE;
         r_aw_held <= 1'b0;
         r_w_held  <= 1'b0;
         r_awaddr  <= '0;
         r_wdata   <= '0;
         r_wstrb   <= '0;
         r_bresp   <= RESP_OKAY;
      end else begin
         r_wstate <= w_wstate_next;
         if (w_commit) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_bresp   <= w_aligned ? RESP_OKAY : RESP_SLVERR;
         end else begin
            if (w_aw_hs) begin
               r_aw_held <= 1'b1;
               r_awaddr  <= s_axi_awaddr_i;
            end
            if (w_w_hs) begin
               r_w_held <= 1'b1;
               r_wdata  <= s_axi_wdata_i;
               r_wstrb  <= s_axi_wstrb_i;
            end
         end
      end
   end

   // ---------------- register storage ----------------
   always_comb begin
      w_old = '0;
      case (w_idx)
         REG_CTRL:       w_old[CTRL_IRQ_EN_BIT] = r_irq_en;
         REG_SRC_ADDR:   w_old = r_src;
         REG_DST_ADDR:   w_old = r_dst;
         REG_COEFF_ADDR: w_old = r_coeff;
         REG_LENGTH:     w_old[15:0] = r_length;
         default:        w_old = '0;
      endcase
   end

   axil_wstrb_merge #(
      .W (DATA_WIDTH)
   ) u_merge (
      .i_old    (w_old),
      .i_wdata  (w_data),
      .i_wstrb  (w_strb),
      .o_merged (w_merged)
   );

   assign w_start_req = w_wr_en && (w_idx == REG_CTRL) && w_data[CTRL_START_BIT] &&
                        w_strb[0] && !core_busy_i;
   assign w_done_clr  = w_wr_en && (w_idx == REG_STATUS) && w_data[STAT_DONE_BIT] && w_strb[0];
   // A completion arriving together with the clear must not be lost.
   assign w_done_next = core_done_i ? 1'b1 : (w_done_clr ? 1'b0 : r_done);

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         r_src    <= '0;
         r_dst    <= '0;
         r_coeff  <= '0;
         r_length <= '0;
         r_irq_en <= 1'b0;
         r_done   <= 1'b0;
         r_start  <= 1'b0;
         r_irq    <= 1'b0;
      end else begin
         r_start <= w_start_req;
         r_done  <= w_done_next;
         r_irq   <= r_done && r_irq_en;
         if (w_wr_en) begin
            case (w_idx)
               REG_CTRL:       r_irq_en <= w_merged[CTRL_IRQ_EN_BIT];
               REG_SRC_ADDR:   r_src    <= w_merged;
               REG_DST_ADDR:   r_dst    <= w_merged;
               REG_COEFF_ADDR: r_coeff  <= w_merged;
               REG_LENGTH:     r_length <= w_merged[15:0];
               default:        ;
            endcase
         end
      end
   end

   assign start_o      = r_start;
   assign irq_o        = r_irq;
   assign src_addr_o   = r_src;
   assign dst_addr_o   = r_dst;
   assign coeff_addr_o = r_coeff;
   assign length_o     = r_length;

   // ---------------- read channel ----------------
   assign s_axi_arready_o = (r_rstate == R_IDLE);
   assign s_axi_rvalid_o  = (r_rstate == R_DATA);
   assign s_axi_rdata_o   = r_rdata;
   assign s_axi_rresp_o   = r_rresp;
   assign w_ar_hs         = s_axi_arvalid_i && s_axi_arready_o;

   always_comb begin
      w_rd_word = '0;
      case (s_axi_araddr_i[4:2])
         REG_CTRL:       w_rd_word[CTRL_IRQ_EN_BIT] = r_irq_en;
         REG_STATUS: begin
            w_rd_word[STAT_BUSY_BIT] = core_busy_i;
            w_rd_word[STAT_DONE_BIT] = r_done;
         end
         REG_SRC_ADDR:   w_rd_word = r_src;
         REG_DST_ADDR:   w_rd_word = r_dst;
         REG_COEFF_ADDR: w_rd_word = r_coeff;
         REG_LENGTH:     w_rd_word[15:0] = r_length;
         REG_ID:         w_rd_word = ID_VALUE;
         default:        w_rd_word = '0;
      endcase
   end

   always_comb begin
      w_rstate_next = r_rstate;
      unique case (r_rstate)
         R_IDLE: if (w_ar_hs) w_rstate_next = R_DATA;
         R_DATA: if (s_axi_rready_i) w_rstate_next = R_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         r_rstate <= R_IDLE;
         r_rdata  <= '0;
         r_rresp  <= RESP_OKAY;
      end else begin
         r_rstate <= w_rstate_next;
         if (w_ar_hs) begin
            if (is_aligned(s_axi_araddr_i[1:0])) begin
               r_rdata <= w_rd_word;
               r_rresp <= RESP_OKAY;
            end else begin
               r_rdata <= '0;
               r_rresp <= RESP_SLVERR;
            end
         end
      end
   end

endmodule

// File: tb/tb_dsp_axil_regs.sv
// Self-checking bench for dsp_axil_regs: directed vector table, hand-written
// handshake corner cases and randomized traffic against a register-map model.
module tb_dsp_axil_regs;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  awaddr, araddr;
   logic        awvalid, wvalid, bready, arvalid, rready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        awready, wready, bvalid, arready, rvalid;
   logic [1:0]  bresp, rresp;
   logic [31:0] rdata;
   logic        busy, done;
   logic        start_o, irq_o;
   logic [31:0] src_o, dst_o, coeff_o;
   logic [15:0] len_o;

   int total = 0;
   int bad = 0;
   int start_cnt = 0;

   always #5 clk = ~clk;
   always @(negedge clk) if (start_o) start_cnt++;

   dsp_axil_regs dut (
      .clk_i           (clk),
      .reset_ni        (rst_n),
      .s_axi_awaddr_i  (awaddr),
      .s_axi_awvalid_i (awvalid),
      .s_axi_awready_o (awready),
      .s_axi_wdata_i   (wdata),
      .s_axi_wstrb_i   (wstrb),
      .s_axi_wvalid_i  (wvalid),
      .s_axi_wready_o  (wready),
      .s_axi_bresp_o   (bresp),
      .s_axi_bvalid_o  (bvalid),
      .s_axi_bready_i  (bready),
      .s_axi_araddr_i  (araddr),
      .s_axi_arvalid_i (arvalid),
      .s_axi_arready_o (arready),
      .s_axi_rdata_o   (rdata),
      .s_axi_rresp_o   (rresp),
      .s_axi_rvalid_o  (rvalid),
      .s_axi_rready_i  (rready),
      .core_busy_i     (busy),
      .core_done_i     (done),
      .start_o         (start_o),
      .src_addr_o      (src_o),
      .dst_addr_o      (dst_o),
      .coeff_addr_o    (coeff_o),
      .length_o        (len_o),
      .irq_o           (irq_o)
   );

   // Behavioural model of the register map
   logic [31:0] m_src, m_dst, m_coeff;
   logic [15:0] m_len;
   logic        m_irq_en, m_done;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] d,
                                          input logic [3:0] s);
      logic [31:0] m;
      m = 32'h0;
      for (int b = 0; b < 4; b++) if (s[b]) m = m | (32'hFF << (8 * b));
      return (o & ~m) | (d & m);
   endfunction

   task automatic model_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                              input logic bsy, output logic [1:0] eresp, output int starts);
      logic [31:0] tmp;
      starts = 0;
      eresp  = 2'b00;
      if (a[1:0] != 2'b00) begin
         eresp = 2'b10;
         return;
      end
      case (a[4:2])
         3'd0: begin
            if (s[0]) m_irq_en = d[1];
            if (s[0] && d[0] && !bsy) starts = 1;
         end
         3'd1: if (s[0] && d[1]) m_done = 1'b0;
         3'd2: m_src = bmerge(m_src, d, s);
         3'd3: m_dst = bmerge(m_dst, d, s);
         3'd4: m_coeff = bmerge(m_coeff, d, s);
         3'd5: begin
            tmp   = bmerge({16'h0, m_len}, d, s);
            m_len = tmp[15:0];
         end
         default: ;
      endcase
   endtask

   function automatic logic [33:0] model_read(input logic [4:0] a, input logic bsy);
      logic [31:0] v;
      if (a[1:0] != 2'b00) return {2'b10, 32'h0};
      case (a[4:2])
         3'd0: v = {30'h0, m_irq_en, 1'b0};
         3'd1: v = {30'h0, m_done, bsy};
         3'd2: v = m_src;
         3'd3: v = m_dst;
         3'd4: v = m_coeff;
         3'd5: v = {16'h0, m_len};
         3'd6: v = 32'hD5C0_0001;
         default: v = 32'h0;
      endcase
      return {2'b00, v};
   endfunction

   task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp);
      int   n;
      logic aw_hs, w_hs;
      n = 0;
      awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1; bready = 1'b1;
      while ((awvalid || wvalid) && n < 20) begin
         aw_hs = awvalid && awready;
         w_hs  = wvalid && wready;
         @(posedge clk); #1;
         if (aw_hs) awvalid = 1'b0;
         if (w_hs) wvalid = 1'b0;
         n++;
      end
      while (!bvalid && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      chk("bvalid_wait", {31'h0, bvalid}, 32'h1);
      resp = bresp;
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
   endtask

   task automatic axi_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] resp);
      int   n;
      logic hs;
      n = 0;
      araddr = a; arvalid = 1'b1; rready = 1'b1;
      while (arvalid && n < 20) begin
         hs = arready;
         @(posedge clk); #1;
         if (hs) arvalid = 1'b0;
         n++;
      end
      while (!rvalid && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      chk("rvalid_wait", {31'h0, rvalid}, 32'h1);
      d    = rdata;
      resp = rresp;
      @(posedge clk); #1;
      arvalid = 1'b0; rready = 1'b0;
   endtask

   task automatic pulse_done();
      done = 1'b1;
      @(posedge clk); #1;
      done = 1'b0;
   endtask

   typedef struct {
      logic [4:0]  wa;
      logic [31:0] wd;
      logic [3:0]  ws;
      logic [1:0]  eb;
      logic [4:0]  ra;
      logic [31:0] er;
      logic [1:0]  err;
   } vec_t;

   vec_t        vecs[12];
   logic [1:0]  resp, rr, eresp;
   logic [31:0] rd;
   logic [33:0] exp_rd;
   logic [4:0]  a, ra;
   logic [31:0] d;
   logic [3:0]  s;
   int          s0, starts;

   initial begin
      vecs[0]  = '{5'h09, 32'hDEADBEEF, 4'hF, 2'b10, 5'h08, 32'h1234_5678, 2'b00};
      vecs[1]  = '{5'h18, 32'hFFFFFFFF, 4'hF, 2'b00, 5'h18, 32'hD5C0_0001, 2'b00};
      vecs[2]  = '{5'h1C, 32'hFFFFFFFF, 4'hF, 2'b00, 5'h1C, 32'h0000_0000, 2'b00};
      vecs[3]  = '{5'h10, 32'hAABBCCDD, 4'hA, 2'b00, 5'h10, 32'hAA00_CC00, 2'b00};
      vecs[4]  = '{5'h0C, 32'h0BADF00D, 4'hF, 2'b00, 5'h0C, 32'h0BAD_F00D, 2'b00};
      vecs[5]  = '{5'h14, 32'hFFFF1234, 4'hF, 2'b00, 5'h14, 32'h0000_1234, 2'b00};
      vecs[6]  = '{5'h0E, 32'h00000001, 4'hF, 2'b10, 5'h0E, 32'h0000_0000, 2'b10};
      vecs[7]  = '{5'h08, 32'h55667788, 4'hC, 2'b00, 5'h08, 32'h5566_5678, 2'b00};
      vecs[8]  = '{5'h00, 32'h00000002, 4'h1, 2'b00, 5'h00, 32'h0000_0002, 2'b00};
      vecs[9]  = '{5'h00, 32'h00000000, 4'h2, 2'b00, 5'h00, 32'h0000_0002, 2'b00};
      vecs[10] = '{5'h04, 32'hFFFFFFFF, 4'hF, 2'b00, 5'h04, 32'h0000_0000, 2'b00};
      vecs[11] = '{5'h00, 32'h00000000, 4'h1, 2'b00, 5'h00, 32'h0000_0000, 2'b00};

      rst_n = 1'b0;
      awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
      araddr = '0; arvalid = 1'b0; rready = 1'b0; busy = 1'b0; done = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_awready", {31'h0, awready}, 32'h1);
      chk("rst_wready", {31'h0, wready}, 32'h1);
      chk("rst_arready", {31'h0, arready}, 32'h1);
      chk("rst_valids", {30'h0, bvalid, rvalid}, 32'h0);
      chk("rst_rdata", rdata, 32'h0);
      chk("rst_outs", {29'h0, start_o, irq_o, |{src_o, dst_o, coeff_o, len_o}}, 32'h0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      // AW and W in the same cycle
      awaddr = 5'h08; awvalid = 1'b1; wdata = 32'h1234_5678; wstrb = 4'hF; wvalid = 1'b1;
      bready = 1'b1;
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0;
      chk("b_latency", {31'h0, bvalid}, 32'h1);
      chk("b_resp_ok", {30'h0, bresp}, 32'h0);
      chk("ready_in_resp", {30'h0, awready, wready}, 32'h0);
      @(posedge clk); #1;
      bready = 1'b0;
      chk("b_done", {29'h0, bvalid, awready, wready}, 32'h3);
      axi_read(5'h08, rd, rr);
      chk("rd_src", rd, 32'h1234_5678);
      chk("rd_src_resp", {30'h0, rr}, 32'h0);

      // W three cycles ahead of AW
      wdata = 32'h0000_ABCD; wstrb = 4'h3; wvalid = 1'b1;
      @(posedge clk); #1;
      wvalid = 1'b0;
      chk("w_ready_drop", {30'h0, wready, awready}, 32'h1);
      repeat (2) begin
         @(posedge clk); #1;
         chk("no_b_without_aw", {31'h0, bvalid}, 32'h0);
      end
      awaddr = 5'h14; awvalid = 1'b1; bready = 1'b1;
      @(posedge clk); #1;
      awvalid = 1'b0;
      chk("b_after_aw", {31'h0, bvalid}, 32'h1);
      chk("len_abcd", {16'h0, len_o}, 32'h0000_ABCD);
      @(posedge clk); #1;
      bready = 1'b0;
      axi_write(5'h14, 32'h0000_00FF, 4'h1, resp);
      chk("len_abff", {16'h0, len_o}, 32'h0000_ABFF);

      // Vector table
      for (int i = 0; i < 12; i++) begin
         s0 = start_cnt;
         axi_write(vecs[i].wa, vecs[i].wd, vecs[i].ws, resp);
         chk($sformatf("vec%0d_bresp", i), {30'h0, resp}, {30'h0, vecs[i].eb});
         axi_read(vecs[i].ra, rd, rr);
         chk($sformatf("vec%0d_rdata", i), rd, vecs[i].er);
         chk($sformatf("vec%0d_rresp", i), {30'h0, rr}, {30'h0, vecs[i].err});
         chk($sformatf("vec%0d_nostart", i), start_cnt - s0, 0);
      end
      chk("src_out", src_o, 32'h5566_5678);

      // START, DONE and interrupt
      s0 = start_cnt;
      axi_write(5'h00, 32'h3, 4'h1, resp);
      chk("start_one_cycle", start_cnt - s0, 1);
      chk("start_low_after", {31'h0, start_o}, 32'h0);
      pulse_done();
      @(posedge clk); #1;
      chk("irq_set", {31'h0, irq_o}, 32'h1);
      axi_read(5'h04, rd, rr);
      chk("status_done", rd, 32'h2);
      axi_write(5'h04, 32'h2, 4'h1, resp);
      chk("irq_clr", {31'h0, irq_o}, 32'h0);
      axi_read(5'h04, rd, rr);
      chk("status_clr", rd, 32'h0);

      busy = 1'b1;
      s0 = start_cnt;
      axi_write(5'h00, 32'h3, 4'h1, resp);
      chk("busy_no_start", start_cnt - s0, 0);
      chk("busy_bresp", {30'h0, resp}, 32'h0);
      pulse_done();
      awaddr = 5'h04; wdata = 32'h2; wstrb = 4'h1; awvalid = 1'b1; wvalid = 1'b1;
      bready = 1'b1; done = 1'b1;
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0; done = 1'b0;
      @(posedge clk); #1;
      bready = 1'b0;
      axi_read(5'h04, rd, rr);
      chk("done_set_wins", rd, 32'h3);
      chk("irq_still_set", {31'h0, irq_o}, 32'h1);
      busy = 1'b0;
      axi_write(5'h04, 32'h2, 4'h1, resp);

      // Randomized traffic against the model
      m_src = 32'h5566_5678; m_dst = 32'h0BAD_F00D; m_coeff = 32'hAA00_CC00;
      m_len = 16'h1234; m_irq_en = 1'b1; m_done = 1'b0;
      for (int i = 0; i < 60; i++) begin
         a = ($urandom_range(0, 3) != 0) ? {3'($urandom_range(0, 7)), 2'b00}
                                         : 5'($urandom_range(0, 31));
         ra = ($urandom_range(0, 3) != 0) ? {3'($urandom_range(0, 7)), 2'b00}
                                          : 5'($urandom_range(0, 31));
         d = $urandom;
         s = 4'($urandom_range(0, 15));
         busy = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 3) == 0) begin
            pulse_done();
            m_done = 1'b1;
         end
         model_write(a, d, s, busy, eresp, starts);
         s0 = start_cnt;
         axi_write(a, d, s, resp);
         chk($sformatf("rnd%0d_bresp@%h", i, a), {30'h0, resp}, {30'h0, eresp});
         chk($sformatf("rnd%0d_start", i), start_cnt - s0, starts);
         chk($sformatf("rnd%0d_irq", i), {31'h0, irq_o}, {31'h0, m_done && m_irq_en});
         exp_rd = model_read(ra, busy);
         axi_read(ra, rd, rr);
         chk($sformatf("rnd%0d_rdata@%h", i, ra), rd, exp_rd[31:0]);
         chk($sformatf("rnd%0d_rresp@%h", i, ra), {30'h0, rr}, {30'h0, exp_rd[33:32]});
      end
      chk("rnd_len_out", {16'h0, len_o}, {16'h0, m_len});
      busy = 1'b0;

      // Stalled responses with read and write to the same word on one edge
      awaddr = 5'h08; wdata = 32'hCAFE_F00D; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
      araddr = 5'h08; arvalid = 1'b1; bready = 1'b0; rready = 1'b0;
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("stall_valids", {30'h0, bvalid, rvalid}, 32'h3);
         chk("stall_readies", {29'h0, awready, wready, arready}, 32'h0);
         chk("stall_rdata_prewrite", rdata, m_src);
         chk("stall_resps", {28'h0, bresp, rresp}, 32'h0);
         @(posedge clk); #1;
      end
      chk("stall_src_new", src_o, 32'hCAFE_F00D);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valids", {30'h0, bvalid, rvalid}, 32'h0);
      chk("arst_readies", {29'h0, awready, wready, arready}, 32'h7);
      chk("arst_rdata", rdata, 32'h0);
      chk("arst_regs", {29'h0, start_o, irq_o, |{src_o, dst_o, coeff_o, len_o}}, 32'h0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      axi_read(5'h0C, rd, rr);
      chk("post_rst_dst", rd, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dsp_axil_regs.md
Name: dsp_axil_regs

Overview:
- AXI4-Lite responder (slave) register file for the DSP 1-D convolution engine; the CPU-side bus interconnect is the initiator.
- Converts AXI-Lite read and write transactions into control and configuration registers for the DSP core.
- Returns status to the CPU and raises an interrupt on completion.

Parameters:
- ADDR_WIDTH, 5, byte address width of the register space (32 bytes, 8 words).
- DATA_WIDTH, 32, AXI data width; WSTRB width is DATA_WIDTH/8.
- ID_VALUE, 32'hD5C0_0001, constant returned by the ID register.

Ports:
- clk_i  in  1  clock.
- reset_ni  in  1  asynchronous, active-low reset.
- s_axi_awaddr_i  in  ADDR_WIDTH  write address.
- s_axi_awvalid_i  in  1  write address valid.
- s_axi_awready_o  out  1  write address ready.
- s_axi_wdata_i  in  DATA_WIDTH  write data.
- s_axi_wstrb_i  in  DATA_WIDTH/8  byte enables.
- s_axi_wvalid_i  in  1  write data valid.
- s_axi_wready_o  out  1  write data ready.
- s_axi_bresp_o  out  2  write response.
- s_axi_bvalid_o  out  1  write response valid.
- s_axi_bready_i  in  1  write response ready.
- s_axi_araddr_i  in  ADDR_WIDTH  read address.
- s_axi_arvalid_i  in  1  read address valid.
- s_axi_arready_o  out  1  read address ready.
- s_axi_rdata_o  out  DATA_WIDTH  read data.
- s_axi_rresp_o  out  2  read response.
- s_axi_rvalid_o  out  1  read data valid.
- s_axi_rready_i  in  1  read data ready.
- core_busy_i  in  1  DSP core busy level.
- core_done_i  in  1  one-cycle pulse when a run completes.
- start_o  out  1  one-cycle start pulse to the core.
- src_addr_o  out  32  input buffer byte address.
- dst_addr_o  out  32  output buffer byte address.
- coeff_addr_o  out  32  coefficient buffer byte address.
- length_o  out  16  sample count.
- irq_o  out  1  interrupt (level).

Behaviour:
- Register map (word index = addr[4:2]):
  - 0 CTRL: bit0 START (write 1 = pulse, reads 0); bit1 IRQ_EN (RW).
  - 1 STATUS: bit0 BUSY (RO, = core_busy_i); bit1 DONE (sticky, W1C).
  - 2 SRC_ADDR, RW.
  - 3 DST_ADDR, RW.
  - 4 COEFF_ADDR, RW.
  - 5 LENGTH, RW, bits[15:0]; bits[31:16] read 0.
  - 6 ID, RO, = ID_VALUE.
  - 7 reserved, reads 0, writes ignored.
- Reset values:
  - All registers 0; start_o=0, irq_o=0.
  - awready/wready/arready=1; bvalid/rvalid=0; bresp/rresp=00; rdata=0.
- Write channel, states W_IDLE / W_RESP:
  - AW and W are accepted independently: each ready drops after its handshake, and the address or data is latched.
  - The commit happens on the edge where both are held, including when both arrive in the same cycle.
  - On commit: bvalid=1 next cycle and FSM moves to W_RESP; awready=wready=0 throughout W_RESP.
  - bvalid is held until bready; on the bvalid&&bready edge FSM returns to W_IDLE and awready=wready=1.
  - Back-to-back AW+W with bready held high completes one write per 2 cycles.
- Write rules:
  - WSTRB byte masking applies to all RW registers.
  - Address with addr[1:0]!=0: bresp=SLVERR (2'b10), no state change.
  - Writes to RO or reserved words: bresp=OKAY, ignored.
- START:
  - A write with wdata[0]=1 and wstrb[0]=1 pulses start_o for exactly one cycle, in the cycle after the commit.
  - Ignored (no pulse, OKAY response) if core_busy_i=1 at commit.
- DONE:
  - Set by core_done_i.
  - Cleared by a write of 1 to bit1 with wstrb[0].
  - Simultaneous set and clear: set wins.
- irq_o is registered: irq_o = DONE && IRQ_EN, with 1 cycle latency.
- Read channel, states R_IDLE / R_DATA:
  - arready=1 only in R_IDLE.
  - On the AR handshake, rdata and rresp are registered and rvalid=1 next cycle.
  - rdata/rresp are held stable until rready; arready returns to 1 the cycle after rvalid&&rready.
  - Misaligned read: rresp=SLVERR, rdata=0.
- Read and write channels are independent.
  - If a read is accepted on the same edge a write commits to the same register, the read returns the pre-write value.
- Reset mid-transaction: all handshakes abort immediately, and outputs return to reset values asynchronously.

Decomposition:
- Shared package dsp_regs_pkg holds:
  - register word indices (REG_CTRL..REG_ID);
  - CTRL/STATUS bit positions;
  - AXI response codes RESP_OKAY=2'b00 and RESP_SLVERR=2'b10;
  - the W/R state encodings.
- One sub-module: axil_wstrb_merge, combinational, merges old value, wdata and wstrb; it is reused for every RW register.
- The channel FSMs and register storage stay in the top module.

Test Plan:
- AW and W same cycle, addr 0x08, data 0x1234_5678, wstrb 4'hF, bready=1 -> bvalid one cycle later with bresp=00; then read 0x08 -> rdata=0x1234_5678, rresp=00.
- W three cycles before AW (addr 0x14, data 0x0000_ABCD, wstrb 4'h3) -> no bvalid until AW arrives; then length_o=16'hABCD; a partial wstrb=4'h1 write of 0xFF -> length_o=16'hABFF.
- Write 0x3 to CTRL with core_busy_i=0 -> start_o high for exactly 1 cycle, IRQ_EN=1; pulse core_done_i -> STATUS reads 0x2, irq_o=1; write 0x2 to STATUS -> DONE=0, irq_o=0.
- START write while core_busy_i=1 -> no start_o pulse, bresp=00; core_done_i pulse in the same cycle as a W1C of DONE -> DONE remains 1.
- Misaligned write to 0x09 -> bresp=SLVERR, SRC_ADDR unchanged; read 0x18 -> ID_VALUE; read 0x1C -> 0.
- Hold bready=0 and rready=0 for 5 cycles -> bvalid/rvalid and data stable, awready/wready/arready stay 0; deassert reset_ni mid-response -> all valids 0 and all readies 1 immediately.
